// File: rtl/sca_mon_pkg.sv
// Shared types and helpers for the switching-activity monitor.
// The optional per-channel peak tracking is selected by SCA_MON_PEAK_EN.
package sca_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mon_state_t;

  // Widest bus the popcount helper handles; narrower buses are zero-extended.
  localparam int unsigned POP_W = 256;

  function automatic int unsigned cnt_width(input int unsigned data_w,
                                            input int unsigned win_log2);
    return $clog2(data_w * (32'd1 << win_log2) + 1);
  endfunction

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sca_mon_channel.sv
// One monitored channel: toggle accumulator, strike counter, sticky alert.
// Peak register is built only when SCA_MON_PEAK_EN is defined.
module sca_mon_channel
  import sca_mon_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned PERSIST = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stop,
  input  logic              win_last,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [CNT_W-1:0]  thresh,
  output logic [CNT_W-1:0]  last_count,
  output logic              alert_ch,
  output logic [CNT_W-1:0]  peak_count
);

  localparam int unsigned STRIKE_W = $clog2(PERSIST + 1);

  logic [DATA_W-1:0]   prev;
  logic                primed;
  logic [CNT_W-1:0]    acc;
  logic [CNT_W-1:0]    acc_nxt;
  logic [CNT_W-1:0]    toggles;
  logic [CNT_W:0]      sum;
  logic [STRIKE_W-1:0] strike;
  logic [STRIKE_W-1:0] strike_nxt;

  // acc_nxt already includes a sample taken on the window's final cycle
  always_comb begin
    toggles = CNT_W'(popcount(POP_W'(data ^ prev)));
    sum     = {1'b0, acc} + {1'b0, toggles};
    acc_nxt = acc;
    if (run && valid && primed) begin
      acc_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_comb begin
    strike_nxt = '0;
    if (acc_nxt > thresh) begin
      strike_nxt = (strike == STRIKE_W'(PERSIST)) ? strike : strike + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      primed     <= 1'b0;
      acc        <= '0;
      last_count <= '0;
      strike     <= '0;
      alert_ch   <= 1'b0;
    end else begin
      if (stop) begin
        acc    <= '0;
        primed <= 1'b0;
      end else begin
        if (run && valid) begin
          prev   <= data;
          primed <= 1'b1;
        end
        acc <= win_last ? '0 : acc_nxt;
        if (win_last) begin
          last_count <= acc_nxt;
        end
      end
      if (clear) begin
        strike   <= '0;
        alert_ch <= 1'b0;
      end else if (win_last) begin
        strike <= strike_nxt;
        if (strike_nxt == STRIKE_W'(PERSIST)) begin
          alert_ch <= 1'b1;
        end
      end
    end
  end

`ifdef SCA_MON_PEAK_EN
  logic [CNT_W-1:0] peak;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      peak <= '0;
    end else if (win_last && (acc_nxt > peak)) begin
      peak <= acc_nxt;
    end
  end

  assign peak_count = peak;
`else
  assign peak_count = '0;
`endif

endmodule

// File: rtl/sca_activity_monitor.sv
// Passive switching-activity monitor: FSM, window counter and NUM_CH channels.
// Define SCA_MON_PEAK_EN to build per-channel peak registers.
module sca_activity_monitor
  import sca_mon_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WIN_LOG2 = 6,
  parameter int unsigned PERSIST  = 3,
  localparam int unsigned CNT_W   = cnt_width(DATA_W, WIN_LOG2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        mon_valid,
  input  logic [NUM_CH*DATA_W-1:0] mon_data,
  input  logic [CNT_W-1:0]         thresh,
  output logic                     window_done,
  output logic [NUM_CH*CNT_W-1:0]  last_count,
  output logic [NUM_CH-1:0]        alert_ch,
  output logic                     alert,
  output logic [NUM_CH*CNT_W-1:0]  peak_count
);

  mon_state_t state;
  mon_state_t state_nxt;
  logic [WIN_LOG2-1:0] win_cnt;
  logic run;
  logic stop;
  logic win_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dropping enable in RUN aborts the window, so a close never coincides with stop
  always_comb begin
    run      = (state == RUN) && enable;
    stop     = (state == RUN) && !enable;
    win_last = run && (win_cnt == '1);
  end

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      win_cnt <= '0;
    end else if (run) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window_done <= 1'b0;
    end else begin
      window_done <= win_last;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sca_mon_channel #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .PERSIST(PERSIST)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .stop      (stop),
      .win_last  (win_last),
      .clear     (clear),
      .valid     (mon_valid[c]),
      .data      (mon_data[c*DATA_W +: DATA_W]),
      .thresh    (thresh),
      .last_count(last_count[c*CNT_W +: CNT_W]),
      .alert_ch  (alert_ch[c]),
      .peak_count(peak_count[c*CNT_W +: CNT_W])
    );
  end

  assign alert = |alert_ch;

endmodule
